// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM state type and the bit-reversal helper for
// the FFT working-memory sequencer.
//   DATA_W : RAM word width (packed complex sample)
//   ADDR_W : log2 of the frame length; also the number of radix-2 stages
//   N      : frame length in points
//   STG_W  : width of the stage index
package fft_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned N      = 1 << ADDR_W;
    localparam int unsigned STG_W  = $clog2(ADDR_W);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_RD,
        S_RDW,
        S_REQ,
        S_WAIT,
        S_WR,
        S_UL_RD,
        S_UL_WAIT,
        S_UL_OUT
    } state_t;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            r[i] = v[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_mem_sequencer_if.sv
// fft_mem_sequencer_if: bundles the sample-load, frame-RAM, butterfly and
// unload handshakes of the FFT memory sequencer.
//   master : sequencer side (drives RAM ports, butterfly requests, output)
//   slave  : environment side (sample source, RAM, butterfly unit, sink)
interface fft_mem_sequencer_if;
    import fft_pkg::*;

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    logic [ADDR_W-1:0] ram_addr_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic              ram_wr_a;
    logic              ram_wr_b;
    logic [DATA_W-1:0] ram_wdata_a;
    logic [DATA_W-1:0] ram_wdata_b;
    logic [DATA_W-1:0] ram_rdata_a;
    logic [DATA_W-1:0] ram_rdata_b;

    logic              bf_req_valid;
    logic              bf_req_ready;
    logic [DATA_W-1:0] bf_x;
    logic [DATA_W-1:0] bf_y;
    logic [ADDR_W-2:0] bf_tw;
    logic              bf_rsp_valid;
    logic [DATA_W-1:0] bf_rsp_x;
    logic [DATA_W-1:0] bf_rsp_y;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    logic              busy;
    logic              done;

    modport master (
        input  start, in_valid, in_data,
        output in_ready,
        output ram_addr_a, ram_addr_b, ram_wr_a, ram_wr_b, ram_wdata_a, ram_wdata_b,
        input  ram_rdata_a, ram_rdata_b,
        output bf_req_valid, bf_x, bf_y, bf_tw,
        input  bf_req_ready, bf_rsp_valid, bf_rsp_x, bf_rsp_y,
        output out_valid, out_data,
        input  out_ready,
        output busy, done
    );

    modport slave (
        output start, in_valid, in_data,
        input  in_ready,
        input  ram_addr_a, ram_addr_b, ram_wr_a, ram_wr_b, ram_wdata_a, ram_wdata_b,
        output ram_rdata_a, ram_rdata_b,
        input  bf_req_valid, bf_x, bf_y, bf_tw,
        output bf_req_ready, bf_rsp_valid, bf_rsp_x, bf_rsp_y,
        input  out_valid, out_data,
        output out_ready,
        input  busy, done
    );

endinterface

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: stage/butterfly counters for the in-place radix-2 DIT
// schedule and the derived operand addresses and twiddle index.
//   clk, rst : clock, asynchronous active-high reset
//   advance  : step to the next butterfly (wraps to stage 0 after the last)
//   addr_a   : top operand address
//   addr_b   : bottom operand address (addr_a + 2^stage)
//   tw       : twiddle index k for W_N^k
//   last     : current butterfly is the final one of the final stage
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [ADDR_W-2:0] tw,
    output logic              last
);

    logic [STG_W-1:0]  stage;
    logic [ADDR_W-2:0] bfly;
    logic [ADDR_W-2:0] k_mask;
    logic [ADDR_W-2:0] k;

    assign last = (stage == STG_W'(ADDR_W - 1)) && (&bfly);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
            bfly  <= '0;
        end else if (advance) begin
            // bfly wraps naturally at N/2; the stage only moves on that wrap
            bfly <= bfly + 1'b1;
            if (&bfly) begin
                stage <= last ? '0 : stage + 1'b1;
            end
        end
    end

    always_comb begin
        k_mask = '0;
        for (int unsigned i = 0; i < ADDR_W - 1; i++) begin
            k_mask[i] = (i < 32'(stage));
        end
        k      = bfly & k_mask;
        addr_a = (({1'b0, bfly} >> stage) << (stage + 1'b1)) + {1'b0, k};
        addr_b = addr_a + (ADDR_W'(1) << stage);
        tw     = k << (STG_W'(ADDR_W - 1) - stage);
    end

endmodule

// File: rtl/fft_mem_sequencer.sv
// fft_mem_sequencer: initiator-side controller for the FFT frame RAM.
// Loads a frame in bit-reversed order, runs the in-place radix-2 DIT
// schedule through an external butterfly unit, then unloads in natural order.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : load / RAM / butterfly / unload handshakes plus busy and done
module fft_mem_sequencer
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fft_mem_sequencer_if.master  bus
);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] bf_x_q;
    logic [DATA_W-1:0] bf_y_q;
    logic [DATA_W-1:0] rsp_x_q;
    logic [DATA_W-1:0] rsp_y_q;
    logic [DATA_W-1:0] out_data_q;
    logic              done_q;

    logic [ADDR_W-1:0] ag_a;
    logic [ADDR_W-1:0] ag_b;
    logic [ADDR_W-2:0] ag_tw;
    logic              ag_last;

    fft_addr_gen u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .advance (state == S_WR),
        .addr_a  (ag_a),
        .addr_b  (ag_b),
        .tw      (ag_tw),
        .last    (ag_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bf_x_q     <= '0;
            bf_y_q     <= '0;
            rsp_x_q    <= '0;
            rsp_y_q    <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    // cnt wraps back to 0 on the last accept, ready for unload
                    if (bus.in_valid) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt) state <= S_RD;
                    end
                end
                S_RD:  state <= S_RDW;
                S_RDW: begin
                    bf_x_q <= bus.ram_rdata_a;
                    bf_y_q <= bus.ram_rdata_b;
                    state  <= S_REQ;
                end
                S_REQ: begin
                    if (bus.bf_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.bf_rsp_valid) begin
                        rsp_x_q <= bus.bf_rsp_x;
                        rsp_y_q <= bus.bf_rsp_y;
                        state   <= S_WR;
                    end
                end
                S_WR:      state <= ag_last ? S_UL_RD : S_RD;
                S_UL_RD:   state <= S_UL_WAIT;
                S_UL_WAIT: begin
                    out_data_q <= bus.ram_rdata_a;
                    state      <= S_UL_OUT;
                end
                S_UL_OUT: begin
                    if (bus.out_ready) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_UL_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready    = 1'b0;
        bus.ram_addr_a  = '0;
        bus.ram_addr_b  = '0;
        bus.ram_wr_a    = 1'b0;
        bus.ram_wr_b    = 1'b0;
        bus.ram_wdata_a = '0;
        bus.ram_wdata_b = '0;
        case (state)
            S_LOAD: begin
                bus.in_ready    = 1'b1;
                bus.ram_addr_a  = bitrev(cnt);
                bus.ram_wr_a    = bus.in_valid;
                bus.ram_wdata_a = bus.in_data;
            end
            S_RD: begin
                bus.ram_addr_a = ag_a;
                bus.ram_addr_b = ag_b;
            end
            S_WR: begin
                bus.ram_addr_a  = ag_a;
                bus.ram_addr_b  = ag_b;
                bus.ram_wr_a    = 1'b1;
                bus.ram_wr_b    = 1'b1;
                bus.ram_wdata_a = rsp_x_q;
                bus.ram_wdata_b = rsp_y_q;
            end
            S_UL_RD: bus.ram_addr_a = cnt;
            default: ;
        endcase
    end

    assign bus.bf_req_valid = (state == S_REQ);
    assign bus.bf_x         = bf_x_q;
    assign bus.bf_y         = bf_y_q;
    assign bus.bf_tw        = ag_tw;
    assign bus.out_valid    = (state == S_UL_OUT);
    assign bus.out_data     = out_data_q;
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = done_q;

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// tb_fft_mem_sequencer: self-checking bench for fft_mem_sequencer with a
// behavioural write-first dual-port RAM, a butterfly responder (loopback or
// arithmetic) and a reference model of the DIT schedule.
module tb_fft_mem_sequencer;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_mem_sequencer_if bus ();

    fft_mem_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- drive variables ----------------
    logic              start_d    = 1'b0;
    logic              in_valid_d = 1'b0;
    logic [DATA_W-1:0] in_data_d  = '0;
    logic              out_ready_d;
    logic              bf_auto = 1'b0;
    logic              bf_arith = 1'b0;
    logic              rnd = 1'b0;
    logic              out_rand = 1'b0;
    logic              rp_ready, rp_valid;
    logic [DATA_W-1:0] rp_x, rp_y;
    logic              mn_ready = 1'b0, mn_valid = 1'b0;
    logic [DATA_W-1:0] mn_x = '0, mn_y = '0;

    assign bus.start        = start_d;
    assign bus.in_valid     = in_valid_d;
    assign bus.in_data      = in_data_d;
    assign bus.out_ready    = out_ready_d;
    assign bus.bf_req_ready = bf_auto ? rp_ready : mn_ready;
    assign bus.bf_rsp_valid = bf_auto ? rp_valid : mn_valid;
    assign bus.bf_rsp_x     = bf_auto ? rp_x : mn_x;
    assign bus.bf_rsp_y     = bf_auto ? rp_y : mn_y;

    // ---------------- write-first dual-port RAM ----------------
    logic [DATA_W-1:0] mem [N];
    always @(posedge clk) begin
        if (bus.ram_wr_a) mem[bus.ram_addr_a] <= bus.ram_wdata_a;
        if (bus.ram_wr_b) mem[bus.ram_addr_b] <= bus.ram_wdata_b;
        bus.ram_rdata_a <= bus.ram_wr_a ? bus.ram_wdata_a : mem[bus.ram_addr_a];
        bus.ram_rdata_b <= bus.ram_wr_b ? bus.ram_wdata_b : mem[bus.ram_addr_b];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    typedef struct {
        int unsigned       a;
        int unsigned       b;
        logic [DATA_W-1:0] da;
        logic [DATA_W-1:0] db;
    } wr_t;
    typedef struct {
        int unsigned       tw;
        int unsigned       c;
    } req_t;

    wr_t               load_log[$];
    wr_t               bfw_log[$];
    req_t              req_log[$];
    logic [DATA_W-1:0] out_q[$];
    int unsigned       done_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.ram_wr_a && !bus.ram_wr_b)
                load_log.push_back('{int'(bus.ram_addr_a), 0, bus.ram_wdata_a, '0});
            if (bus.ram_wr_a && bus.ram_wr_b)
                bfw_log.push_back('{int'(bus.ram_addr_a), int'(bus.ram_addr_b),
                                   bus.ram_wdata_a, bus.ram_wdata_b});
            if (bus.bf_req_valid && bus.bf_req_ready)
                req_log.push_back('{int'(bus.bf_tw), cyc});
            if (bus.out_valid && bus.out_ready)
                out_q.push_back(bus.out_data);
            if (bus.done) done_cnt++;
        end
    end

    // ---------------- butterfly responder ----------------
    initial begin
        logic              pend;
        int unsigned       wait_n;
        logic [DATA_W-1:0] rx, ry;
        pend = 1'b0; wait_n = 0; rx = '0; ry = '0;
        rp_ready = 1'b0; rp_valid = 1'b0; rp_x = '0; rp_y = '0;
        forever begin
            @(negedge clk);
            if (bf_auto && bus.bf_req_valid && bus.bf_req_ready) begin
                pend   = 1'b1;
                wait_n = rnd ? $urandom_range(0, 3) : 0;
                if (bf_arith) begin
                    rx = bus.bf_x + bus.bf_y + DATA_W'(bus.bf_tw);
                    ry = bus.bf_x - bus.bf_y - DATA_W'(bus.bf_tw);
                end else begin
                    rx = bus.bf_x;
                    ry = bus.bf_y;
                end
            end
            @(posedge clk); #2;
            rp_valid = 1'b0;
            if (pend) begin
                if (wait_n == 0) begin
                    rp_valid = 1'b1; rp_x = rx; rp_y = ry; pend = 1'b0;
                end else begin
                    wait_n--;
                end
            end else if (rnd && ($urandom % 4 == 0)) begin
                // stray strobe outside WAIT; must have no effect
                rp_valid = 1'b1; rp_x = DATA_W'($urandom); rp_y = DATA_W'($urandom);
            end
            rp_ready = rnd ? 1'($urandom % 2) : 1'b1;
        end
    end

    // ---------------- output sink ----------------
    initial begin
        out_ready_d = 1'b0;
        forever begin
            @(posedge clk); #2;
            out_ready_d = out_rand ? 1'($urandom % 2) : 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_zero(input string name);
        logic [127:0] v;
        v = {bus.in_ready, bus.ram_addr_a, bus.ram_addr_b, bus.ram_wr_a, bus.ram_wr_b,
             bus.ram_wdata_a, bus.ram_wdata_b, bus.bf_req_valid, bus.bf_x, bus.bf_y,
             bus.bf_tw, bus.out_valid, bus.out_data, bus.busy, bus.done};
        check(name, v, '0);
    endtask

    function automatic int unsigned tb_rev(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < ADDR_W; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    logic [DATA_W-1:0] frame   [N];
    logic [DATA_W-1:0] exp_out [N];

    // Reference: classic DIT loops over group size, not stage/butterfly index.
    task automatic build_model();
        logic [DATA_W-1:0] m [N];
        logic [DATA_W-1:0] x, y;
        int unsigned a, b, tw;
        for (int unsigned n = 0; n < N; n++) m[tb_rev(n)] = frame[n];
        for (int unsigned size = 2; size <= N; size *= 2)
            for (int unsigned base = 0; base < N; base += size)
                for (int unsigned k = 0; k < size / 2; k++) begin
                    a = base + k; b = a + size / 2; tw = k * (N / size);
                    x = m[a]; y = m[b];
                    m[a] = x + y + DATA_W'(tw);
                    m[b] = x - y - DATA_W'(tw);
                end
        for (int unsigned i = 0; i < N; i++) exp_out[i] = m[i];
    endtask

    task automatic start_frame(input bit chk);
        @(posedge clk); #2; start_d = 1'b1;
        @(negedge clk); if (chk) check("in_ready_before_start", bus.in_ready, 0);
        @(posedge clk); #2; start_d = 1'b0;
        @(negedge clk); if (chk) check("in_ready_after_start", bus.in_ready, 1);
    endtask

    task automatic load_frame(input bit gaps);
        int unsigned n, guard;
        n = 0; guard = 0;
        while (n < N && guard < 2000) begin
            @(posedge clk); #2;
            in_valid_d = gaps ? ($urandom % 3 != 0) : 1'b1;
            in_data_d  = frame[n];
            @(negedge clk);
            if (in_valid_d && bus.in_ready) n++;
            guard++;
        end
        @(posedge clk); #2; in_valid_d = 1'b0; in_data_d = '0;
        check("load_accepts", n, N);
    endtask

    task automatic wait_done(input int unsigned target);
        int unsigned guard;
        guard = 0;
        while (done_cnt < target && guard < 20000) begin
            @(negedge clk); guard++;
        end
        check("done_reached", done_cnt >= target, 1);
    endtask

    typedef struct { int unsigned n; int unsigned addr; } ld_vec_t;
    typedef struct { int unsigned idx; int unsigned a; int unsigned b; int unsigned tw; } bf_vec_t;

    // ---------------- main sequence ----------------
    initial begin
        ld_vec_t ld_tab [5];
        bf_vec_t bf_tab [3];
        int unsigned lb, bb, rb, ob, db, bad;
        logic [DATA_W-1:0] sx, sy;
        logic [ADDR_W-2:0] stw;

        ld_tab = '{'{0, 0}, '{1, 16}, '{2, 8}, '{3, 24}, '{31, 31}};
        bf_tab = '{'{0, 0, 1, 0}, '{17, 1, 3, 8}, '{79, 15, 31, 15}};

        // reset, then reset in the middle of a load
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); check_zero("reset_outputs");
        for (int unsigned n = 0; n < N; n++) frame[n] = DATA_W'(n);
        start_frame(1);
        repeat (5) begin
            @(posedge clk); #2; in_valid_d = 1'b1; in_data_d = 16'h00aa;
        end
        @(posedge clk); #2; rst = 1'b1; in_valid_d = 1'b0;
        @(negedge clk); check_zero("reset_mid_load");
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk); check("busy_after_reset", bus.busy, 0);

        // run A: loopback butterfly at full rate, random sink
        bf_auto = 1'b1; bf_arith = 1'b0; rnd = 1'b0; out_rand = 1'b1;
        lb = load_log.size(); bb = bfw_log.size(); rb = req_log.size();
        ob = out_q.size(); db = done_cnt;
        start_frame(1);
        load_frame(0);
        @(negedge clk); check("in_ready_low_after_32", bus.in_ready, 0);
        check("load_writes", load_log.size() - lb, N);
        foreach (ld_tab[i]) begin
            check("load_addr", load_log[lb + ld_tab[i].n].a, ld_tab[i].addr);
            check("load_data", load_log[lb + ld_tab[i].n].da, ld_tab[i].n);
        end
        bad = 0;
        for (int unsigned n = 0; n < N; n++)
            if (load_log[lb + n].a != tb_rev(n) || load_log[lb + n].da != DATA_W'(n)) bad++;
        check("load_all_bitrev", bad, 0);

        repeat (100) @(negedge clk);
        check("busy_during_compute", bus.busy, 1);
        @(posedge clk); #2; start_d = 1'b1;
        repeat (3) @(posedge clk);
        #2 start_d = 1'b0;
        wait_done(db + 1);
        repeat (6) @(negedge clk);

        check("req_count", req_log.size() - rb, 80);
        check("bf_write_count", bfw_log.size() - bb, 80);
        foreach (bf_tab[i]) begin
            check("bf_addr_a", bfw_log[bb + bf_tab[i].idx].a, bf_tab[i].a);
            check("bf_addr_b", bfw_log[bb + bf_tab[i].idx].b, bf_tab[i].b);
            check("bf_tw", req_log[rb + bf_tab[i].idx].tw, bf_tab[i].tw);
        end
        bad = 0;
        for (int unsigned i = 1; i < 80; i++)
            if (req_log[rb + i].c - req_log[rb + i - 1].c != 5) bad++;
        check("req_spacing_5", bad, 0);
        check("out_transfers", out_q.size() - ob, N);
        for (int unsigned k = 0; k < N; k++)
            check("out_bitrev", out_q[ob + k], tb_rev(k));
        check("done_pulses", done_cnt - db, 1);
        check("idle_after_done", bus.busy, 0);

        // run B: butterfly backpressure with a stray response, then abort
        bf_auto = 1'b0; mn_ready = 1'b0; mn_valid = 1'b0;
        bb = bfw_log.size();
        start_frame(0);
        load_frame(0);
        bad = 0;
        while (!bus.bf_req_valid && bad < 50) begin
            @(negedge clk); bad++;
        end
        check("bp_req_seen", bus.bf_req_valid, 1);
        sx = bus.bf_x; sy = bus.bf_y; stw = bus.bf_tw;
        check("bp_x_operand", sx, frame[0]);
        check("bp_y_operand", sy, frame[16]);
        bad = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            mn_valid = (i == 3); mn_x = 16'hdead; mn_y = 16'hbeef;
            @(negedge clk);
            if (!bus.bf_req_valid || bus.bf_x != sx || bus.bf_y != sy || bus.bf_tw != stw ||
                bus.ram_wr_a || bus.ram_wr_b) bad++;
        end
        check("bp_stable_no_write", bad, 0);
        @(posedge clk); #2; mn_valid = 1'b0; mn_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #2; mn_ready = 1'b0; mn_valid = 1'b1; mn_x = 16'h1234; mn_y = 16'h5678;
        @(posedge clk); #2; mn_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_write_count", bfw_log.size() - bb, 1);
        check("bp_write_a", {bfw_log[bb].a, bfw_log[bb].da}, {32'd0, 16'h1234});
        check("bp_write_b", {bfw_log[bb].b, bfw_log[bb].db}, {32'd1, 16'h5678});
        @(posedge clk); #2; rst = 1'b1;
        @(negedge clk); check_zero("reset_mid_compute");
        @(posedge clk); #2; rst = 1'b0;

        // run C: random data, arithmetic butterfly, random latencies and sink
        bf_auto = 1'b1; bf_arith = 1'b1; rnd = 1'b1; out_rand = 1'b1;
        for (int unsigned n = 0; n < N; n++) frame[n] = DATA_W'($urandom);
        build_model();
        rb = req_log.size(); ob = out_q.size(); db = done_cnt;
        start_frame(0);
        load_frame(1);
        wait_done(db + 1);
        repeat (6) @(negedge clk);
        check("rand_req_count", req_log.size() - rb, 80);
        check("rand_out_transfers", out_q.size() - ob, N);
        for (int unsigned k = 0; k < N; k++)
            check("rand_out_data", out_q[ob + k], exp_out[k]);
        check("rand_done_pulses", done_cnt - db, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
